// File: rtl/coincidence_binner_pkg.sv
// Shared types and constants for the coincidence binner front end.
package coinc_pkg;

  // Acquisition FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

  // Default bin address width and the matching window length in cycles
  localparam int BIN_W_DEF  = 7;
  localparam int WINDOW_DEF = 1 << BIN_W_DEF;

  // Width of the host-visible statistics counters
  localparam int CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/coincidence_binner_sync_edge_detect.sv
// Synchronizes one asynchronous detector line and produces a one-cycle
// pulse on each rising edge. The "previous" register comes out of reset
// high and only starts tracking once the synchronizer chain holds real
// post-reset samples, so a line held high through reset never looks like
// a fresh edge: it has to be observed low first.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   prev_r;
  logic                   rise_r;

  // Synchronizer chain, fill tracker and registered rising-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      fill_r <= '0;
      prev_r <= 1'b1;
      rise_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      fill_r <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      if (fill_r[SYNC_STAGES-1]) begin
        prev_r <= sync_r[SYNC_STAGES-1];
        rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
      end else begin
        prev_r <= prev_r;
        rise_r <= 1'b0;
      end
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/coincidence_binner.sv
// Start/stop coincidence front end: measures the A-to-B delay in clock
// cycles, emits a bin address with a one-cycle increment strobe, and keeps
// saturating event / timeout statistics for the host.
module coincidence_binner
  import coinc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BIN_W       = BIN_W_DEF,
  parameter int DEAD_TIME   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_a,
  input  logic             ch_b,
  input  logic             enable,
  input  logic             clear_stats,
  output logic [BIN_W-1:0] bin_addr,
  output logic             bin_valid,
  output logic [CNT_W-1:0] event_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  // Dead-time counter runs 0 .. DEAD_TIME-1; keep it at least one bit wide
  localparam int                DEAD_W    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
  localparam bit                HAS_DEAD  = (DEAD_TIME > 0);
  localparam logic [BIN_W-1:0]  CNT_MAX   = BIN_W'((1 << BIN_W) - 1);

  logic              rise_a_s;
  logic              rise_b_s;

  state_e            state_r;
  state_e            state_n;
  logic [BIN_W-1:0]  cnt_r;
  logic [BIN_W-1:0]  cnt_n;
  logic [DEAD_W-1:0] dead_r;
  logic [DEAD_W-1:0] dead_n;

  logic              rec_s;
  logic [BIN_W-1:0]  rec_bin_s;
  logic              tmo_s;

  logic [BIN_W-1:0]  bin_addr_r;
  logic              bin_valid_r;
  logic [CNT_W-1:0]  event_cnt_r;
  logic [CNT_W-1:0]  event_cnt_n;
  logic [CNT_W-1:0]  timeout_cnt_r;
  logic [CNT_W-1:0]  timeout_cnt_n;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk  (clk),
    .rst  (rst),
    .din  (ch_a),
    .rise (rise_a_s)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk  (clk),
    .rst  (rst),
    .din  (ch_b),
    .rise (rise_b_s)
  );

  // Next-state logic: arming, delay counting, recording, timeout and blanking
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    dead_n    = dead_r;
    rec_s     = 1'b0;
    rec_bin_s = '0;
    tmo_s     = 1'b0;
    if (!enable) begin
      // Dropping enable discards any armed start or pending blanking
      state_n = ST_IDLE;
      cnt_n   = '0;
      dead_n  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_a_s && rise_b_s) begin
            rec_s     = 1'b1;
            rec_bin_s = '0;
            cnt_n     = '0;
            dead_n    = '0;
            if (HAS_DEAD) begin
              state_n = ST_DEAD;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (rise_a_s) begin
            cnt_n   = BIN_W'(1);
            state_n = ST_ARMED;
          end else begin
            // A stop with no start is a stray count
            state_n = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (rise_b_s) begin
            // Stop wins over a simultaneous (re)start
            rec_s     = 1'b1;
            rec_bin_s = cnt_r;
            cnt_n     = '0;
            dead_n    = '0;
            if (HAS_DEAD) begin
              state_n = ST_DEAD;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (cnt_r == CNT_MAX) begin
            // Window exhausted; the counter never wraps
            tmo_s   = 1'b1;
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt_r + BIN_W'(1);
          end
        end
        ST_DEAD: begin
          if (dead_r >= DEAD_LAST) begin
            dead_n  = '0;
            state_n = ST_IDLE;
          end else begin
            dead_n = dead_r + DEAD_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          dead_n  = '0;
        end
      endcase
    end
  end

  // Statistics next values; clear beats a coincident increment
  always_comb begin
    event_cnt_n   = event_cnt_r;
    timeout_cnt_n = timeout_cnt_r;
    if (clear_stats) begin
      event_cnt_n   = '0;
      timeout_cnt_n = '0;
    end else begin
      if (rec_s) begin
        event_cnt_n = sat_inc(event_cnt_r);
      end else begin
        event_cnt_n = event_cnt_r;
      end
      if (tmo_s) begin
        timeout_cnt_n = sat_inc(timeout_cnt_r);
      end else begin
        timeout_cnt_n = timeout_cnt_r;
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      dead_r        <= '0;
      bin_addr_r    <= '0;
      bin_valid_r   <= 1'b0;
      event_cnt_r   <= '0;
      timeout_cnt_r <= '0;
    end else begin
      state_r       <= state_n;
      cnt_r         <= cnt_n;
      dead_r        <= dead_n;
      bin_valid_r   <= rec_s;
      event_cnt_r   <= event_cnt_n;
      timeout_cnt_r <= timeout_cnt_n;
      if (rec_s) begin
        bin_addr_r <= rec_bin_s;
      end else begin
        bin_addr_r <= bin_addr_r;
      end
    end
  end

  assign bin_addr    = bin_addr_r;
  assign bin_valid   = bin_valid_r;
  assign event_cnt   = event_cnt_r;
  assign timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_coincidence_binner.sv
// Self-checking bench for coincidence_binner: a time-stamp based model of
// the start/stop rules checked every cycle, plus literal per-scenario pins.
module tb_coincidence_binner;

  localparam int SYNC   = 2;
  localparam int BW     = 7;
  localparam int DEAD   = 4;
  localparam int WINDOW = 1 << BW;

  logic          clk;
  logic          rst;
  logic          ch_a;
  logic          ch_b;
  logic          enable;
  logic          clear_stats;
  logic [BW-1:0] bin_addr;
  logic          bin_valid;
  logic [31:0]   event_cnt;
  logic [31:0]   timeout_cnt;

  coincidence_binner #(
    .SYNC_STAGES (SYNC),
    .BIN_W       (BW),
    .DEAD_TIME   (DEAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_a        (ch_a),
    .ch_b        (ch_b),
    .enable      (enable),
    .clear_stats (clear_stats),
    .bin_addr    (bin_addr),
    .bin_valid   (bin_valid),
    .event_cnt   (event_cnt),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int last_bin = 0;

  // Model state: time stamps instead of counters
  int          cyc = 0;
  int          n_post = 0;
  bit          armed = 0;
  int          start_cyc = 0;
  int          blank_until = 0;
  bit          m_ra = 0;
  bit          m_rb = 0;
  bit          m_valid = 0;
  int          m_bin = 0;
  logic [31:0] m_ev = 32'd0;
  logic [31:0] m_to = 32'd0;
  bit          sa_a [0:SYNC+1];
  bit          sa_b [0:SYNC+1];

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic record(input int b);
    m_valid     = 1'b1;
    m_bin       = b;
    m_ev        = sat32(m_ev);
    armed       = 1'b0;
    blank_until = cyc + DEAD + 1;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step();
    int d;
    m_valid = 1'b0;
    if (rst) begin
      m_ev = 32'd0; m_to = 32'd0; m_bin = 0;
      armed = 1'b0; blank_until = 0;
      m_ra = 1'b0; m_rb = 1'b0; n_post = 0;
    end else begin
      // Edges seen in the previous cycle act now (stamp = cyc)
      if (!enable) begin
        armed = 1'b0; blank_until = 0;
      end else if (cyc < blank_until) begin
        armed = 1'b0;
      end else if (armed) begin
        d = cyc - start_cyc;
        if (m_rb) record(d);
        else if (d >= WINDOW - 1) begin
          armed = 1'b0;
          m_to  = sat32(m_to);
        end
      end else if (m_ra && m_rb) begin
        record(0);
      end else if (m_ra) begin
        armed = 1'b1; start_cyc = cyc;
      end
      if (clear_stats) begin
        m_ev = 32'd0; m_to = 32'd0;
      end
      // A rise is a sample high S edges ago whose predecessor was low,
      // both taken after reset
      for (int j = SYNC + 1; j > 0; j--) begin
        sa_a[j] = sa_a[j-1];
        sa_b[j] = sa_b[j-1];
      end
      sa_a[0] = ch_a;
      sa_b[0] = ch_b;
      n_post++;
      m_ra = (n_post >= SYNC + 2) && sa_a[SYNC] && !sa_a[SYNC+1];
      m_rb = (n_post >= SYNC + 2) && sa_b[SYNC] && !sa_b[SYNC+1];
    end
    cyc++;
  endtask

  task automatic compare();
    chk("bin_valid", bin_valid, m_valid);
    if (m_valid) chk("bin_addr", bin_addr, m_bin);
    chk("event_cnt", event_cnt, m_ev);
    chk("timeout_cnt", timeout_cnt, m_to);
    if (bin_valid) begin
      n_strobe++;
      last_bin = bin_addr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  // Drive 2-cycle pulses at the given indices (-1 = unused) for n cycles
  task automatic drive_seq(input int ta, input int ta2, input int tb, input int tb2,
                           input int en_off, input int clr_at, input int rst_at,
                           input int n);
    for (int i = 0; i < n; i++) begin
      ch_a = (ta  >= 0 && i >= ta  && i < ta  + 2) || (ta2 >= 0 && i >= ta2 && i < ta2 + 2);
      ch_b = (tb  >= 0 && i >= tb  && i < tb  + 2) || (tb2 >= 0 && i >= tb2 && i < tb2 + 2);
      enable      = !(en_off >= 0 && i >= en_off);
      clear_stats = (i == clr_at);
      rst         = (i == rst_at);
      tick();
    end
    ch_a = 1'b0; ch_b = 1'b0; enable = 1'b1; clear_stats = 1'b0; rst = 1'b0;
  endtask

  int s0;

  initial begin
    rst = 1'b1; ch_a = 1'b0; ch_b = 1'b0; enable = 1'b1; clear_stats = 1'b0;
    repeat (3) tick();
    chk("reset_bin_valid", bin_valid, 0);
    chk("reset_bin_addr", bin_addr, 0);
    chk("reset_event_cnt", event_cnt, 0);
    chk("reset_timeout_cnt", timeout_cnt, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Delay 10
    s0 = n_strobe;
    drive_seq(0, -1, 10, -1, -1, -1, -1, 25);
    chk("delay10_strobes", n_strobe - s0, 1);
    chk("delay10_bin", last_bin, 10);
    chk("delay10_events", event_cnt, 1);

    // Simultaneous start and stop
    s0 = n_strobe;
    drive_seq(0, -1, 0, -1, -1, -1, -1, 15);
    chk("simul_strobes", n_strobe - s0, 1);
    chk("simul_bin", last_bin, 0);

    // Last bin of the window
    s0 = n_strobe;
    drive_seq(0, -1, 127, -1, -1, -1, -1, 140);
    chk("d127_strobes", n_strobe - s0, 1);
    chk("d127_bin", last_bin, 127);

    // One past the window: timeout, stop ignored
    s0 = n_strobe;
    drive_seq(0, -1, 128, -1, -1, -1, -1, 145);
    chk("d128_strobes", n_strobe - s0, 0);
    chk("d128_timeouts", timeout_cnt, 1);
    chk("d128_events", event_cnt, 3);

    // Start 2 cycles after stop is blanked; later stop finds IDLE
    s0 = n_strobe;
    drive_seq(0, 12, 10, 25, -1, -1, -1, 40);
    chk("dead2_strobes", n_strobe - s0, 1);
    chk("dead2_bin", last_bin, 10);

    // Start exactly DEAD_TIME after stop is still blanked
    s0 = n_strobe;
    drive_seq(0, 14, 10, 17, -1, -1, -1, 35);
    chk("dead4_strobes", n_strobe - s0, 1);

    // Start DEAD_TIME+1 after stop is accepted
    s0 = n_strobe;
    drive_seq(0, 15, 10, 18, -1, -1, -1, 35);
    chk("dead5_strobes", n_strobe - s0, 2);
    chk("dead5_bin", last_bin, 3);
    chk("dead5_events", event_cnt, 7);

    // Retrigger while armed: first start wins
    s0 = n_strobe;
    drive_seq(0, 5, 20, -1, -1, -1, -1, 35);
    chk("retrig_strobes", n_strobe - s0, 1);
    chk("retrig_bin", last_bin, 20);

    // Stray stop in IDLE
    s0 = n_strobe;
    drive_seq(-1, -1, 3, -1, -1, -1, -1, 15);
    chk("stray_strobes", n_strobe - s0, 0);

    // Enable dropped while armed
    s0 = n_strobe;
    drive_seq(0, -1, 10, -1, 5, -1, -1, 25);
    chk("enoff_strobes", n_strobe - s0, 0);
    chk("enoff_events", event_cnt, 8);
    chk("enoff_timeouts", timeout_cnt, 1);

    // Clear coinciding with the recording edge
    s0 = n_strobe;
    drive_seq(0, -1, 4, -1, -1, 7, -1, 20);
    chk("clr_strobes", n_strobe - s0, 1);
    chk("clr_events", event_cnt, 0);
    chk("clr_timeouts", timeout_cnt, 0);

    // Saturation: preload just below all-ones, then two events
    force dut.event_cnt_r = 32'hFFFF_FFFE;
    m_ev = 32'hFFFF_FFFE;
    tick();
    release dut.event_cnt_r;
    tick();
    drive_seq(0, -1, 6, -1, -1, -1, -1, 20);
    chk("sat_first", event_cnt, 32'hFFFF_FFFF);
    drive_seq(0, -1, 6, -1, -1, -1, -1, 20);
    chk("sat_hold", event_cnt, 32'hFFFF_FFFF);

    // Reset while armed
    s0 = n_strobe;
    drive_seq(0, -1, 10, -1, -1, -1, 5, 25);
    chk("rst_strobes", n_strobe - s0, 0);
    chk("rst_events", event_cnt, 0);
    chk("rst_bin_addr", bin_addr, 0);

    // Start line held high through reset release produces no edge
    s0 = n_strobe;
    ch_a = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      ch_b = (i >= 5 && i < 7);
      tick();
    end
    ch_a = 1'b0; ch_b = 1'b0;
    repeat (5) tick();
    chk("held_strobes", n_strobe - s0, 0);
    chk("held_events", event_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
